// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive frame filter.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    ADDR,
    PASS,
    DROP
  } rx_state_e;

  localparam int          MAC_BYTES     = 6;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  // Byte k of a MAC address in wire order (k=0 is mac[47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    logic [47:0] t;
    t = mac << (8 * int'(k));
    return t[47:40];
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 step over one dibit (bit 0 first).
// Only built when RX_FCS_CHECK_EN is defined; the CRC register lives in the parent.
`ifdef RX_FCS_CHECK_EN
module crc32_dibit
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [1:0]  dibit_i,
  output logic [31:0] crc_o
);

  // Two serial LFSR steps, LSB of the dibit first.
  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit_i[i]) c = (c >> 1) ^ CRC32_POLY;
      else                   c = c >> 1;
    end
    crc_o = c;
  end

endmodule
`endif

// File: rtl/rx_frame_filter.sv
// RMII receive destination-address filter: packs dibits into bytes, matches the
// destination MAC against MAC_ADDR (or broadcast) and forwards the rest of the frame.
// Optional feature macro: RX_FCS_CHECK_EN enables the CRC-32 FCS verdict.
//
// state     | meaning
// WAIT_IDLE | after reset, wait for a gap so we never lock on mid-frame
// IDLE      | between frames, first dibit of a new frame starts ADDR
// ADDR      | collecting the 6 destination bytes, nothing forwarded
// PASS      | address matched, every completed byte is strobed out
// DROP      | address missed, swallow until end of frame
module rx_frame_filter
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       done,
  output logic       fcs_ok
);

  rx_state_e   state_q, state_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [5:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        uni_ok_q, uni_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic        axiov_q, axiov_d;
  logic [7:0]  axiod_q, axiod_d;
  logic        done_q, done_d;
  logic        fcs_ok_q, fcs_ok_d;
  logic [7:0]  byte_w;
  logic        byte_done;
  logic        fcs_good;

  assign byte_w    = {axiid, shift_q};
  assign byte_done = axiiv && (dcnt_q == 2'd3);

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_src, crc_nxt;

  // The first dibit of a frame is taken in IDLE, so seed the step with the init value there.
  assign crc_src = (state_q == IDLE) ? CRC32_INIT : crc_q;

  crc32_dibit u_crc (
    .crc_i  (crc_src),
    .dibit_i(axiid),
    .crc_o  (crc_nxt)
  );

  // CRC advances on every frame dibit, destination and FCS included.
  always_comb begin
    crc_d = crc_q;
    if (axiiv && state_q != WAIT_IDLE) crc_d = crc_nxt;
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC32_INIT;
    else        crc_q <= crc_d;
  end

  assign fcs_good = (crc_q == CRC32_RESIDUE);
`else
  assign fcs_good = 1'b1;
`endif

  // Next-state, byte packing, address match and output generation.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    uni_ok_d = uni_ok_q;
    bc_ok_d  = bc_ok_q;
    axiov_d  = 1'b0;
    axiod_d  = axiod_q;
    done_d   = 1'b0;
    fcs_ok_d = fcs_ok_q;

    if (axiiv && (state_q == ADDR || state_q == PASS || state_q == DROP)) begin
      dcnt_d = dcnt_q + 2'd1;
      case (dcnt_q)
        2'd0:    shift_d[1:0] = axiid;
        2'd1:    shift_d[3:2] = axiid;
        2'd2:    shift_d[5:4] = axiid;
        default: shift_d      = shift_q;
      endcase
    end

    case (state_q)
      WAIT_IDLE: begin
        if (!axiiv) state_d = IDLE;
      end
      IDLE: begin
        if (axiiv) begin
          shift_d  = {4'b0, axiid};
          dcnt_d   = 2'd1;
          idx_d    = 3'd0;
          uni_ok_d = 1'b1;
          bc_ok_d  = ACCEPT_BCAST;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (!axiiv) begin
          dcnt_d  = 2'd0;
          state_d = IDLE;
        end else if (byte_done) begin
          uni_ok_d = uni_ok_q && (byte_w == mac_byte(MAC_ADDR, idx_q));
          bc_ok_d  = bc_ok_q && (byte_w == mac_byte(BCAST_MAC, idx_q));
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'(MAC_BYTES - 1)) state_d = (uni_ok_d || bc_ok_d) ? PASS : DROP;
        end
      end
      PASS: begin
        if (!axiiv) begin
          done_d   = 1'b1;
          fcs_ok_d = (dcnt_q == 2'd0) && fcs_good;
          dcnt_d   = 2'd0;
          state_d  = IDLE;
        end else if (byte_done) begin
          axiov_d = 1'b1;
          axiod_d = byte_w;
        end
      end
      DROP: begin
        if (!axiiv) begin
          dcnt_d  = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_IDLE;
      dcnt_q   <= 2'd0;
      shift_q  <= 6'd0;
      idx_q    <= 3'd0;
      uni_ok_q <= 1'b0;
      bc_ok_q  <= 1'b0;
      axiov_q  <= 1'b0;
      axiod_q  <= 8'd0;
      done_q   <= 1'b0;
      fcs_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      uni_ok_q <= uni_ok_d;
      bc_ok_q  <= bc_ok_d;
      axiov_q  <= axiov_d;
      axiod_q  <= axiod_d;
      done_q   <= done_d;
      fcs_ok_q <= fcs_ok_d;
    end
  end

  assign axiov  = axiov_q;
  assign axiod  = axiod_q;
  assign done   = done_q;
  assign fcs_ok = fcs_ok_q;

endmodule

// File: tb/tb_rx_frame_filter.sv
// Directed bench for rx_frame_filter: unicast, broadcast, miss, FCS, runt/partial,
// mid-frame reset. A second instance has broadcast acceptance disabled.
module tb_rx_frame_filter;

  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov, done, fcs_ok;
  logic [7:0] axiod;
  logic       axiov_b, done_b, fcs_ok_b;
  logic [7:0] axiod_b;

  always #10 clk = ~clk;

  rx_frame_filter #(.MAC_ADDR(MY_MAC), .ACCEPT_BCAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .done(done), .fcs_ok(fcs_ok)
  );

  rx_frame_filter #(.MAC_ADDR(MY_MAC), .ACCEPT_BCAST(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov_b), .axiod(axiod_b), .done(done_b), .fcs_ok(fcs_ok_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Observation counters, cleared before each frame.
  logic [7:0] got_b[0:255];
  int nstb, ndone, dbl, ovl, nstb_b, ndone_b;
  logic last_fcs, prev_ov;

  task automatic clr();
    nstb = 0; ndone = 0; dbl = 0; ovl = 0; nstb_b = 0; ndone_b = 0;
    last_fcs = 1'b0; prev_ov = 1'b0;
  endtask

  always @(negedge clk) begin
    if (axiov) begin
      if (nstb < 256) got_b[nstb] = axiod;
      nstb++;
    end
    if (axiov && prev_ov) dbl++;
    prev_ov = axiov;
    if (done) begin
      ndone++;
      last_fcs = fcs_ok;
      if (axiov) ovl++;
    end
    if (axiov_b) nstb_b++;
    if (done_b) ndone_b++;
  end

  logic [7:0] frm[$];

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // dst + src 02:AA:BB:CC:DD:EE + ethertype 0800 + payload + FCS; optional bit flip afterwards.
  task automatic make_frame(input logic [47:0] dst, input int paylen, input bit flip);
    logic [47:0] src;
    logic [31:0] f;
    src = 48'h02_AA_BB_CC_DD_EE;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47 - 8*i -: 8]);
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    for (int i = 0; i < paylen; i++) frm.push_back(8'((i * 7 + 3) & 8'hFF));
    f = fcs_of(frm.size());
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    if (flip) frm[20] = frm[20] ^ 8'h10;
  endtask

  // Send up to ndib dibits of frm; optional reset pulse starting at dibit rst_at.
  task automatic send(input int ndib, input int rst_at, input int gap);
    int n;
    logic [7:0] cur;
    n = 0;
    clr();
    for (int b = 0; b < frm.size(); b++) begin
      cur = frm[b];
      for (int j = 0; j < 4; j++) begin
        if (n < ndib) begin
          if (n == rst_at) rst_n = 1'b0;
          if (rst_at >= 0 && n == rst_at + 2)
            chk("rst_mid_outs", {53'd0, axiov, done, fcs_ok, axiod}, 64'd0);
          if (rst_at >= 0 && n == rst_at + 6) begin
            rst_n = 1'b1;
            clr();
          end
          axiiv = 1'b1;
          axiid = cur[2*j +: 2];
          @(posedge clk); #1;
          n++;
        end
      end
    end
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Compare forwarded bytes against frm[6..6+n-1].
  task automatic chk_fwd(input string tag, input int exp_n);
    int nbad;
    nbad = 0;
    for (int i = 0; i < exp_n && i < 256; i++) if (got_b[i] !== frm[6 + i]) nbad++;
    chk({tag, "_bytes"}, 64'(nbad), 64'd0);
  endtask

  localparam int FULL = 1 << 20;
`ifdef RX_FCS_CHECK_EN
  localparam logic BAD_FCS_EXP = 1'b0;
`else
  localparam logic BAD_FCS_EXP = 1'b1;
`endif

  initial begin
    rst_n = 1'b0;
    axiiv = 1'b0;
    axiid = 2'b00;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {53'd0, axiov, done, fcs_ok, axiod}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1. unicast hit, 64-byte frame
    make_frame(MY_MAC, 46, 1'b0);
    send(FULL, -1, 4);
    chk("uni_nstb", 64'(nstb), 64'd58);
    chk("uni_first", {56'd0, got_b[0]}, 64'h02);
    chk_fwd("uni", 58);
    chk("uni_done", 64'(ndone), 64'd1);
    chk("uni_fcs", {63'd0, last_fcs}, 64'd1);
    chk("uni_nb_nstb", 64'(nstb_b), 64'd58);

    // 2. broadcast: passes on dut, dropped by dut_nb
    make_frame(48'hFFFF_FFFF_FFFF, 46, 1'b0);
    send(FULL, -1, 4);
    chk("bc_nstb", 64'(nstb), 64'd58);
    chk("bc_done", 64'(ndone), 64'd1);
    chk("bc_nb_nstb", 64'(nstb_b), 64'd0);
    chk("bc_nb_done", 64'(ndone_b), 64'd0);

    // 3. miss, then a hit after a single idle cycle
    make_frame(48'h02_00_00_00_00_02, 46, 1'b0);
    send(FULL, -1, 1);
    chk("miss_nstb", 64'(nstb), 64'd0);
    chk("miss_done", 64'(ndone), 64'd0);
    make_frame(MY_MAC, 50, 1'b0);
    send(FULL, -1, 4);
    chk("hit1gap_nstb", 64'(nstb), 64'd62);
    chk_fwd("hit1gap", 62);
    chk("hit1gap_done", 64'(ndone), 64'd1);

    // 4. corrupted payload bit
    make_frame(MY_MAC, 46, 1'b1);
    send(FULL, -1, 4);
    chk("badfcs_done", 64'(ndone), 64'd1);
    chk("badfcs_fcs", {63'd0, last_fcs}, {63'd0, BAD_FCS_EXP});

    // 5a. runt: 3 bytes only
    make_frame(MY_MAC, 46, 1'b0);
    send(12, -1, 4);
    chk("runt_nstb", 64'(nstb), 64'd0);
    chk("runt_done", 64'(ndone), 64'd0);

    // 5b. partial: one dibit into byte 20
    send(20 * 4 + 1, -1, 4);
    chk("part_nstb", 64'(nstb), 64'd14);
    chk_fwd("part", 14);
    chk("part_done", 64'(ndone), 64'd1);
    chk("part_fcs", {63'd0, last_fcs}, 64'd0);

    // 6. reset at byte 10, released while axiiv still high
    send(FULL, 40, 4);
    chk("rstmid_nstb", 64'(nstb), 64'd0);
    chk("rstmid_done", 64'(ndone), 64'd0);
    send(FULL, -1, 4);
    chk("after_rst_nstb", 64'(nstb), 64'd58);
    chk("after_rst_done", 64'(ndone), 64'd1);
    chk("after_rst_fcs", {63'd0, last_fcs}, 64'd1);
    chk("strobe_width", 64'(dbl), 64'd0);
    chk("done_ov_overlap", 64'(ovl), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1);
  end

endmodule
